// File: rtl/stream_mux_nx1_pkg.sv
// stream_mux_nx1_pkg: shared channel-selection policy encoding for the stream mux
package stream_mux_nx1_pkg;
  typedef enum logic [1:0] {
    MUX_FIXED = 2'd0,
    MUX_RR    = 2'd1,
    MUX_SEL   = 2'd2
  } mux_mode_e;
endpackage

// File: rtl/stream_mux_nx1_if.sv
// stream_mux_nx1_if: N-channel valid/ready inputs plus one registered valid/ready output
interface stream_mux_nx1_if #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int IW = $clog2(N)
);
  logic [IW-1:0] sel;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0] out_chan;
  logic out_ready;
  modport master (output sel, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_chan);
  modport slave (input sel, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_chan);
endinterface

// File: rtl/mux_arbiter_n.sv
// mux_arbiter_n: combinational grant (fixed priority, rotating, or external select) as one-hot plus index
module mux_arbiter_n
  import stream_mux_nx1_pkg::*;
#(
  parameter int N = 4,
  parameter mux_mode_e MODE = MUX_RR,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] sel,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  logic [IW-1:0] idx, scan_idx;
  logic scan_valid, sel_valid;
  assign sel_valid = (int'(sel) < N) ? req[sel] : 1'b0;
  // Scan from the start point (0 or ptr) downwards so the lowest offset with a request wins
  always_comb begin
    scan_valid = 1'b0;
    scan_idx = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'(((MODE == MUX_RR) ? int'(ptr) + k : k) % N);
      if (req[idx]) begin
        scan_valid = 1'b1;
        scan_idx = idx;
      end
    end
  end
  assign gnt_valid = (MODE == MUX_SEL) ? sel_valid : scan_valid;
  assign gnt_idx = (MODE == MUX_SEL) ? sel : scan_idx;
  assign gnt = gnt_valid ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-to-1 stream mux with a single output register and full-throughput handshake
module stream_mux_nx1
  import stream_mux_nx1_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MODE = 1,
  localparam int IW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  stream_mux_nx1_if.slave bus
);
  logic can_load, take, gnt_valid;
  logic [N-1:0] gnt;
  logic [IW-1:0] gnt_idx, ptr_q, ptr_d, out_chan_q, out_chan_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  mux_arbiter_n #(.N(N), .MODE(mux_mode_e'(MODE))) u_arb (
    .req(bus.in_valid),
    .sel(bus.sel),
    .ptr(ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );
  assign can_load = !out_valid_q || bus.out_ready;
  assign take = can_load && gnt_valid;
  assign bus.in_ready = can_load ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_chan = out_chan_q;
  // Load on an input transfer, drain on a lone output transfer, otherwise hold; ptr moves past the winner
  always_comb begin
    out_valid_d = take || (out_valid_q && !bus.out_ready);
    out_data_d = take ? bus.in_data[gnt_idx] : out_data_q;
    out_chan_d = take ? gnt_idx : out_chan_q;
    ptr_d = take ? ((int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end
  // Output register and rotate pointer; reset drops any held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: scoreboard bench over fixed, round-robin, select, N=2 and N=16 builds
module tb_stream_mux_nx1;
  typedef struct {
    int chan;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cur = 0;
  int m_mode, m_n, m_ptr;
  logic m_ov;
  logic [63:0] m_mask;
  logic [15:0] d_valid = '0;
  logic [3:0] d_sel = '0;
  logic d_out_ready = 1'b1;
  logic [15:0][63:0] d_data = '0;
  logic [15:0] v_in_ready;
  logic v_out_valid;
  logic [63:0] v_out_data;
  logic [3:0] v_out_chan;
  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;
  stream_mux_nx1_if #(.WIDTH(32), .N(4)) i0 (), i1 (), i2 ();
  stream_mux_nx1_if #(.WIDTH(8), .N(2)) i3 ();
  stream_mux_nx1_if #(.WIDTH(64), .N(16)) i4 ();
  stream_mux_nx1 #(.WIDTH(32), .N(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  stream_mux_nx1 #(.WIDTH(32), .N(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  stream_mux_nx1 #(.WIDTH(32), .N(4), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  stream_mux_nx1 #(.WIDTH(8), .N(2), .MODE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));
  stream_mux_nx1 #(.WIDTH(64), .N(16), .MODE(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  always #5 clk = ~clk;
  assign i0.in_valid = (cur == 0) ? d_valid[3:0] : '0;
  assign i1.in_valid = (cur == 1) ? d_valid[3:0] : '0;
  assign i2.in_valid = (cur == 2) ? d_valid[3:0] : '0;
  assign i3.in_valid = (cur == 3) ? d_valid[1:0] : '0;
  assign i4.in_valid = (cur == 4) ? d_valid : '0;
  assign i0.sel = d_sel[1:0];
  assign i1.sel = d_sel[1:0];
  assign i2.sel = d_sel[1:0];
  assign i3.sel = d_sel[0];
  assign i4.sel = d_sel;
  assign i0.out_ready = d_out_ready;
  assign i1.out_ready = d_out_ready;
  assign i2.out_ready = d_out_ready;
  assign i3.out_ready = d_out_ready;
  assign i4.out_ready = d_out_ready;
  // Fan the shared 16x64 stimulus out to each build's narrower data ports
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      i0.in_data[c] = d_data[c][31:0];
      i1.in_data[c] = d_data[c][31:0];
      i2.in_data[c] = d_data[c][31:0];
    end
    for (int c = 0; c < 2; c++) i3.in_data[c] = d_data[c][7:0];
    i4.in_data = d_data;
  end
  // Present the active build's outputs zero-extended to a common width
  always_comb begin
    v_in_ready = '0;
    v_out_valid = 1'b0;
    v_out_data = '0;
    v_out_chan = '0;
    case (cur)
      0: begin v_in_ready = 16'(i0.in_ready); v_out_valid = i0.out_valid; v_out_data = 64'(i0.out_data); v_out_chan = 4'(i0.out_chan); end
      1: begin v_in_ready = 16'(i1.in_ready); v_out_valid = i1.out_valid; v_out_data = 64'(i1.out_data); v_out_chan = 4'(i1.out_chan); end
      2: begin v_in_ready = 16'(i2.in_ready); v_out_valid = i2.out_valid; v_out_data = 64'(i2.out_data); v_out_chan = 4'(i2.out_chan); end
      3: begin v_in_ready = 16'(i3.in_ready); v_out_valid = i3.out_valid; v_out_data = 64'(i3.out_data); v_out_chan = 4'(i3.out_chan); end
      4: begin v_in_ready = i4.in_ready; v_out_valid = i4.out_valid; v_out_data = i4.out_data; v_out_chan = i4.out_chan; end
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d): got %h expected %h", tag, cur, got, exp);
    end
  endtask
  function automatic int model_grant(input int mode, input int n, input logic [15:0] v, input int ptr, input int sel);
    int i;
    if (mode == 2) return (sel < n && v[sel[3:0]]) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      i = (mode == 1) ? (ptr + k) % n : k;
      if (v[i[3:0]]) return i;
    end
    return -1;
  endfunction
  task automatic cycle();
    int g;
    logic [15:0] exp_rdy;
    logic load;
    #1;
    g = model_grant(m_mode, m_n, d_valid, m_ptr, int'(d_sel));
    load = (g >= 0) && (!m_ov || d_out_ready);
    exp_rdy = load ? 16'(1) << g : '0;
    check("in_ready", 64'(v_in_ready), 64'(exp_rdy));
    check("out_valid", 64'(v_out_valid), 64'(m_ov));
    if (m_ov && q.size() > 0) begin
      check("out_data", v_out_data, q[0].data);
      check("out_chan", 64'(v_out_chan), 64'(q[0].chan));
    end
    @(posedge clk);
    if (m_ov && d_out_ready && q.size() > 0) void'(q.pop_front());
    if (load) begin
      q.push_back('{g, d_data[g[3:0]] & m_mask});
      m_ptr = (g + 1) % m_n;
      m_ov = 1'b1;
    end else if (d_out_ready) m_ov = 1'b0;
    #1;
  endtask
  task automatic start(input int c, input int mode, input int n, input int w);
    cur = c;
    m_mode = mode;
    m_n = n;
    m_mask = (w == 64) ? '1 : (64'(1) << w) - 64'(1);
    m_ov = 1'b0;
    m_ptr = 0;
    q.delete();
    d_valid = '0;
    d_sel = '0;
    d_out_ready = 1'b1;
  endtask
  task automatic new_data();
    for (int c = 0; c < 16; c++) d_data[c] = {$urandom, $urandom};
  endtask
  task automatic drain();
    d_valid = '0;
    d_out_ready = 1'b1;
    repeat (2) cycle();
    check("drained", 64'(q.size()), 64'd0);
  endtask
  task automatic scen_rr_bp(input int cycles);
    logic [63:0] hold;
    d_valid = '1;
    d_out_ready = 1'b1;
    repeat (cycles) begin
      new_data();
      cycle();
    end
    d_out_ready = 1'b0;
    hold = v_out_data;
    repeat (3) begin
      new_data();
      cycle();
      check("bp_hold", v_out_data, hold);
    end
    d_out_ready = 1'b1;
    cycle();
    check("bp_reload_valid", 64'(v_out_valid), 64'd1);
    drain();
  endtask
  initial begin
    logic [3:0] pats [4] = '{4'b1010, 4'b0110, 4'b1000, 4'b1111};
    repeat (2) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      cur = c;
      #1;
      check("rst_valid", 64'(v_out_valid), 64'd0);
      check("rst_data", v_out_data, 64'd0);
      check("rst_chan", 64'(v_out_chan), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    start(0, 0, 4, 32);
    foreach (pats[p]) begin
      new_data();
      d_valid = 16'(pats[p]);
      cycle();
    end
    drain();
    start(1, 1, 4, 32);
    scen_rr_bp(6);
    d_valid = '1;
    repeat (3) begin
      new_data();
      cycle();
    end
    d_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(v_out_valid), 64'd0);
    check("async_rst_data", v_out_data, 64'd0);
    check("async_rst_chan", 64'(v_out_chan), 64'd0);
    q.delete();
    m_ov = 1'b0;
    m_ptr = 0;
    @(negedge clk) rst_n = 1'b1;
    d_out_ready = 1'b1;
    cycle();
    check("post_rst_chan", 64'(v_out_chan), 64'd0);
    drain();
    start(2, 2, 4, 32);
    new_data();
    d_sel = 4'd2;
    d_valid = 16'b0001;
    repeat (3) cycle();
    d_valid = 16'b0101;
    d_data[2] = 64'hDEADBEEF;
    cycle();
    check("sel_data", v_out_data, 64'hDEADBEEF);
    check("sel_chan", 64'(v_out_chan), 64'd2);
    d_sel = 4'd0;
    new_data();
    cycle();
    drain();
    start(3, 1, 2, 8);
    scen_rr_bp(6);
    start(4, 1, 16, 64);
    scen_rr_bp(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_nx1.md
STREAM_MUX_NX1 -- requirements
Module: stream_mux_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel in bits.
REQ-002 SHALL have parameter N, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL have parameter MODE, default 1, channel-selection policy: 0 = fixed priority, 1 = round-robin, 2 = external select.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sel, input, $clog2(N), external channel index; used only when MODE=2.
REQ-007 SHALL have port in_valid, input, N, per-channel valid.
REQ-008 SHALL have port in_data, input, N x WIDTH, per-channel data.
REQ-009 SHALL have port in_ready, output, N, per-channel ready; at most one bit high per cycle.
REQ-010 SHALL have port out_valid, output, 1, output register holds a word.
REQ-011 SHALL have port out_data, output, WIDTH, registered data.
REQ-012 SHALL have port out_chan, output, $clog2(N), source channel of out_data.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 SHALL transfer on an input when in_valid[i] and in_ready[i] are both high at a rising edge, and on the output when out_valid and out_ready are both high.
REQ-015 SHALL compute can_load = !out_valid || out_ready; in_ready[g] = can_load for the granted channel g only; all other in_ready bits low.
REQ-016 SHALL grant, in MODE 0, the lowest-indexed channel with in_valid high.
REQ-017 SHALL grant, in MODE 1, the first valid channel searching upward from pointer ptr with wrap from N-1 to 0.
REQ-018 SHALL update ptr to (g+1) mod N only on an accepted input transfer; ptr SHALL hold otherwise.
REQ-019 SHALL grant, in MODE 2, channel sel if in_valid[sel] is high, else no grant; sel >= N SHALL grant nothing.
REQ-020 SHALL load out_data <= in_data[g], out_chan <= g, and out_valid <= 1 on an input transfer, giving a latency of exactly one cycle.
REQ-021 SHALL clear out_valid on an output transfer with no simultaneous input transfer.
REQ-022 SHALL support a simultaneous output and input transfer in one cycle, giving full throughput of one word per cycle with out_valid staying high.
REQ-023 SHALL hold out_data and out_chan stable while out_valid && !out_ready.
REQ-024 SHALL drive all in_ready low when no channel is valid, and SHALL not change ptr in that case.
REQ-025 SHALL not depend on in_ready for in_valid; in_ready SHALL depend combinationally on out_ready and in_valid only.

Reset
REQ-026 SHALL, while rst_n is low and independently of clk, force out_valid=0, out_data=0, out_chan=0, and ptr=0.
REQ-027 SHALL discard, on reset asserted mid-transfer, any held word without it being presented to downstream.
REQ-028 SHALL resume arbitration from channel 0 on the first rising edge after rst_n rises.

Structure
REQ-029 SHALL place the MODE encoding as an enum (MUX_FIXED, MUX_RR, MUX_SEL) in the shared datapath package.
REQ-030 SHALL implement the grant logic (fixed, rotate, select) in one sub-module, mux_arbiter_n, parametrised by N and MODE, that outputs a one-hot grant and its index.
REQ-031 SHALL keep the output register and handshake in stream_mux_nx1.

Verification
REQ-032 SHALL verify MODE=0, N=4: in_valid=4'b1010 with out_ready=1 gives channel 1 data out next cycle, out_chan=1, and in_ready=4'b0010.
REQ-033 SHALL verify MODE=1, N=4: all channels valid, out_ready=1 for 6 cycles gives out_chan sequence 0,1,2,3,0,1 with one word per cycle.
REQ-034 SHALL verify backpressure: out_valid=1 and out_ready=0 for 3 cycles keeps out_data constant and in_ready=0; in_data change is ignored; out_ready=1 gives one output transfer plus one new load.
REQ-035 SHALL verify MODE=2: sel=2 with in_valid=4'b0001 gives no grant and out_valid stays 0; setting in_valid[2]=1 with in_data[2]=0xDEADBEEF gives out_data=0xDEADBEEF and out_chan=2.
REQ-036 SHALL verify reset: rst_n=0 asynchronously mid-stream drives out_valid=0 immediately, before the next edge, and the first grant after reset in MODE 1 goes to channel 0.
REQ-037 SHALL verify edge cases: N=2 with WIDTH=8 and N=16 with WIDTH=64 builds pass scenarios 033 and 034, including ptr wrap from N-1 to 0.
